// File: rtl/flag_timer_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : flag_timer_arbiter_if
// Brief    : Requester-side bundle for the shared interval-timer arbiter.
// Revision : 1.0
// ============================================================================
interface flag_timer_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int N_BIT = 5
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*N_BIT-1:0] load_val;
    logic [N_REQ-1:0]       grant;
    logic [ID_W-1:0]        cur_id;
    logic                   busy;
    logic [N_BIT-1:0]       count;
    logic [N_REQ-1:0]       done;

    modport master (
        output req, load_val,
        input  grant, cur_id, busy, count, done
    );

    modport slave (
        input  req, load_val,
        output grant, cur_id, busy, count, done
    );
endinterface
`default_nettype wire

// File: rtl/flag_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : flag_timer_arbiter
// Brief    : Round-robin arbitration of one down-counting timer among N_REQ
//            requesters, with a one-cycle done pulse to the winner.
// Revision : 1.0
// ============================================================================
module flag_timer_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int N_BIT = 5
) (
    input  wire logic             clk_p,
    input  wire logic             rst_n,
    flag_timer_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [N_REQ-1:0]   r_done;
    logic [ID_W-1:0]    r_cur_id;
    logic [ID_W-1:0]    r_last;
    logic [N_BIT-1:0]   r_count;
    logic               r_busy;

    logic               w_found_hi;
    logic               w_found_lo;
    logic [ID_W-1:0]    w_hi_id;
    logic [ID_W-1:0]    w_lo_id;
    logic [ID_W-1:0]    w_win_id;
    logic               w_any;
    logic [N_REQ-1:0]   w_win_onehot;
    logic [N_BIT-1:0]   w_win_load;
    logic               w_owner_req;

    // Round-robin: lowest requesting index above r_last wins, else the
    // lowest requesting index at or below it (wrap-around).
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_hi_id    = '0;
        w_lo_id    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                if (ID_W'(i) > r_last) begin
                    w_found_hi = 1'b1;
                    w_hi_id    = ID_W'(i);
                end else begin
                    w_found_lo = 1'b1;
                    w_lo_id    = ID_W'(i);
                end
            end
        end
        w_any    = w_found_hi | w_found_lo;
        w_win_id = w_found_hi ? w_hi_id : w_lo_id;
    end

    always_comb begin
        w_win_onehot = '0;
        w_win_load   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == w_win_id) begin
                w_win_onehot[i] = w_any;
                w_win_load      = bus.load_val[i*N_BIT +: N_BIT];
            end
        end
    end

    assign w_owner_req = |(bus.req & r_grant);

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_done   <= '0;
            r_cur_id <= '0;
            r_last   <= ID_W'(N_REQ - 1);
            r_count  <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant  <= w_win_onehot;
                        r_cur_id <= w_win_id;
                        r_last   <= w_win_id;
                        r_count  <= w_win_load;
                        r_busy   <= 1'b1;
                        r_state  <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    // Abort is tested first so a drop at count==0 yields no done.
                    if (!w_owner_req) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_count <= '0;
                        r_state <= ST_IDLE;
                    end else if (r_count == '0) begin
                        r_done  <= r_grant;
                        r_state <= ST_DONE;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_count <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_count <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.grant  = r_grant;
    assign bus.cur_id = r_cur_id;
    assign bus.busy   = r_busy;
    assign bus.count  = r_count;
    assign bus.done   = r_done;

endmodule
`default_nettype wire

// File: doc/flag_timer_arbiter.md
# flag_timer_arbiter

Shared-timer scheduler that arbitrates one down-counting interval timer among N_REQ requesters. Each requester asks for a timeout of its own programmed length. The block grants the timer round-robin, runs the count, and returns a one-cycle done pulse to the winner. It sits between the control FSMs that need timeouts and the counter resource, so several agents can share a single counter.

## Interface
- N_REQ, 4: number of requesters (2..8).
- ID_W, 2: width of the winner index; must satisfy 2**ID_W >= N_REQ.
- N_BIT, 5: timer/load width.

- clk_p  in  1  single clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  per-requester request level; held until done or deliberately dropped (abort).
- load_val  in  N_REQ*N_BIT  packed load values; requester i uses load_val[i*N_BIT +: N_BIT]; sampled only at grant.
- grant  out  N_REQ  one-hot, registered; high from grant through the DONE cycle.
- cur_id  out  ID_W  index of current winner; valid while busy.
- busy  out  1  timer owned (COUNT or DONE state).
- count  out  N_BIT  current timer value.
- done  out  N_REQ  one-hot one-cycle pulse to the winner on expiry.

## Operation
- FSM states:
  - IDLE: arbitrate; if any req bit is high, grant the winner and load count, then go to COUNT. Otherwise stay.
  - COUNT: if req[cur_id]==0, abort to IDLE. Else if count==0, go to DONE. Else count <= count-1.
  - DONE: done[cur_id]=1, grant held; go to IDLE unconditionally.
- Leaving DONE or aborting clears grant, busy and count to 0.
- Arbitration is round-robin. Search starts at (last+1) mod N_REQ, ascending with wrap.
  - last is a register, updated to the winner's index at grant.
  - Reset value of last is N_REQ-1, so req[0] has the highest priority after reset.
- Only one grant is outstanding at any time. Requests arriving during COUNT/DONE wait; nothing is queued beyond the req levels themselves.
- Count never wraps: it stops at 0. No arithmetic is wider than N_BIT.
- Abort has priority over expiry: if req[cur_id] drops in the cycle count==0, the state returns to IDLE with no done pulse.
- A requester that keeps req high after its done is eligible again, but at lowest priority.
- Out-of-range indices (≥N_REQ) are never granted.

## Timing
- Reset (async assert, sync deassert by the environment): state=IDLE, grant=0, cur_id=0, busy=0, count=0, done=0, last=N_REQ-1.
- Grant latency: with req high before edge E in IDLE, grant, busy, cur_id and count=L are valid after edge E.
- Expiry: count reaches 0 after L further edges. DONE follows one edge later.
  - The done pulse is high for exactly 1 cycle, L+1 cycles after grant rose.
  - L=0 gives one COUNT cycle, then DONE.
- Turnaround: DONE → IDLE (1 cycle) → next grant. The minimum gap between a done pulse and the next grant rising is 1 IDLE cycle; grant is low for 1 cycle between owners.
- Abort: req[cur_id] low before edge E in COUNT means grant, busy and count are 0 after E. A new grant is possible at E+1.
- Reset asserted mid-COUNT: all outputs go to 0 immediately, with no done pulse.

## Test plan
- Single requester: reset, then req=4'b0001 with load 3 → grant=0001 one cycle after req. Count goes 3,2,1,0, then done[0] pulses for 1 cycle exactly 4 cycles after grant. busy then falls.
- Round-robin: all req=4'b1111 held continuously, loads 1 → grant order 0,1,2,3,0. One IDLE gap cycle between owners; done pulses in the same order.
- Zero load: req[2] with load 0 → grant, COUNT at 0 for one cycle, then done[2] on the next cycle. Count never shows 31 (no wrap).
- Abort: req[1] granted with load 10; drop req[1] when count=5 → grant=0 and busy=0 next cycle, no done. A pending req[3] is granted the cycle after.
- Abort/expiry collision: drop req[cur_id] in the cycle count==0 → no done pulse, return to IDLE.
- Async reset mid-count: pulse rst_n low between edges while count=7 → all outputs 0 immediately. After release, req[3] and req[0] together → req[0] wins.
